twiddle_fetch: RTL and testbench

Twiddle-factor fetch stage for the 512-point FFT. It accepts a twiddle index k from the butterfly address generator and reads the 512-entry cosine ROM twice: once for cos(2πk/512) and once at the quarter-period-shifted address for sin. It returns the complex twiddle W = cos − j·sin, or its conjugate for the inverse transform, through a valid/ready handshake. It sits directly upstream of the cosine ROM: it drives the ROM address and consumes the ROM's registered data.

---
 rtl/twiddle_fetch.sv | 81 ++++++++
 tb/tb_twiddle_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_fetch.sv
// Twiddle-factor fetch for the 512-point FFT: two reads of the cosine ROM
// (k and k-N/4) assembled into W = cos - j*sin, or its conjugate for the inverse.
module twiddle_fetch #(
  parameter int D_WIDTH = 10,
  parameter int A_WIDTH = 9
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [A_WIDTH-1:0] req_k,
  input  logic               req_inv,
  output logic [A_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0] rom_data,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic [D_WIDTH-1:0] tw_re,
  output logic [D_WIDTH-1:0] tw_im,
  output logic [A_WIDTH-1:0] tw_k
);
  localparam logic [A_WIDTH-1:0] QTR   = A_WIDTH'(1) << (A_WIDTH-2);
  localparam logic [D_WIDTH-1:0] D_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [D_WIDTH-1:0] D_MAX = ~D_MIN;

  typedef enum logic [2:0] {IDLE, S_COS, S_SIN, S_IM, S_OUT} state_t;
  state_t state, state_nxt;

  logic [A_WIDTH-1:0] k_q;
  logic               inv_q;
  logic               accept;
  logic [D_WIDTH-1:0] neg_sin;

  assign req_ready = (state == IDLE) || (state == S_OUT && tw_ready);
  assign accept    = req_valid && req_ready;
  // Negating the most-negative code would overflow; clamp to full-scale positive.
  assign neg_sin   = (rom_data == D_MIN) ? D_MAX : (~rom_data + D_WIDTH'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = S_COS;
      S_COS:   state_nxt = S_SIN;
      S_SIN:   state_nxt = S_IM;
      S_IM:    state_nxt = S_OUT;
      S_OUT:   if (accept) state_nxt = S_COS;
               else if (tw_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      k_q      <= '0;
      inv_q    <= 1'b0;
      rom_addr <= '0;
      tw_valid <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
      tw_k     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_COS: rom_addr <= k_q - QTR;
        S_SIN: tw_re    <= rom_data;
        S_IM: begin
          tw_im    <= inv_q ? rom_data : neg_sin;
          tw_valid <= 1'b1;
        end
        S_OUT: if (tw_ready) tw_valid <= 1'b0;
        default: ;
      endcase
      if (accept) begin
        rom_addr <= req_k;
        k_q      <= req_k;
        inv_q    <= req_inv;
        tw_k     <= req_k;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_fetch.sv
// Scoreboard bench for twiddle_fetch with a registered cosine-ROM model.
module tb_twiddle_fetch;
  localparam int D = 10, A = 9, N = 512;

  logic         clk = 1'b0, rstn = 1'b0;
  logic         req_valid = 1'b0, req_inv = 1'b0, tw_ready = 1'b1;
  logic [A-1:0] req_k = '0;
  logic         req_ready, tw_valid;
  logic [A-1:0] rom_addr, tw_k;
  logic [D-1:0] rom_data = '0, tw_re, tw_im;

  twiddle_fetch #(.D_WIDTH(D), .A_WIDTH(A)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_k(req_k), .req_inv(req_inv), .rom_addr(rom_addr), .rom_data(rom_data),
    .tw_valid(tw_valid), .tw_ready(tw_ready), .tw_re(tw_re), .tw_im(tw_im), .tw_k(tw_k)
  );

  always #5 clk = ~clk;

  logic [D-1:0] rom_mem [N];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct packed { logic [A-1:0] k; logic [D-1:0] re; logic [D-1:0] im; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  function automatic exp_t model(input logic [A-1:0] k, input logic inv);
    exp_t r; int s; logic [A-1:0] a;
    a = k - 9'd128;
    s = int'($signed(rom_mem[a]));
    if (!inv) begin s = -s; if (s > 511) s = 511; end
    r.k = k; r.re = rom_mem[k]; r.im = D'(s);
    return r;
  endfunction

  always @(negedge clk)
    if (rstn && req_valid && req_ready) sb.push_back(model(req_k, req_inv));

  task automatic load_rom();
    for (int i = 0; i < N; i++) rom_mem[i] = D'(i - 256);
  endtask

  // Present one request; returns #1 after the accept edge (IDLE accepts at once).
  task automatic send(input logic [A-1:0] k, input logic inv);
    @(posedge clk); #1;
    req_valid = 1'b1; req_k = k; req_inv = inv;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'($urandom); req_k = A'($urandom); req_inv = 1'($urandom);
      tw_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({tw_valid, tw_re, tw_im, tw_k, rom_addr} !== '0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset: valid=%b re=%h im=%h k=%h addr=%h rdy=%b req 0s,rdy=1",
                 tw_valid, tw_re, tw_im, tw_k, rom_addr, req_ready);
      end
    end
    req_valid = 1'b0; tw_ready = 1'b1;
    @(posedge clk); #1; rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tw_valid !== 1'b0) begin failures++; $display("FAIL reset_idle: tw_valid=%b req 0", tw_valid); end
    end
    sb.delete();
  endtask

  task automatic test_forward();
    exp_t e;
    send(9'd128, 1'b0);
    @(negedge clk); checks++;
    if (rom_addr !== 9'd128 || tw_valid !== 1'b0) begin failures++; $display("FAIL fwd_addr0: addr=%0d valid=%b req 128,0", rom_addr, tw_valid); end
    @(negedge clk); checks++;
    if (rom_addr !== 9'd0 || tw_valid !== 1'b0) begin failures++; $display("FAIL fwd_addr1: addr=%0d valid=%b req 0,0", rom_addr, tw_valid); end
    @(negedge clk); checks++;
    if (tw_valid !== 1'b0) begin failures++; $display("FAIL fwd_early: tw_valid=%b req 0", tw_valid); end
    @(negedge clk); checks++;
    if (tw_valid !== 1'b1 || sb.size() == 0) begin
      failures++; $display("FAIL fwd_latency: tw_valid=%b sb=%0d req valid at +3", tw_valid, sb.size());
    end else begin
      e = sb.pop_front(); checks++;
      if ({tw_k, tw_re, tw_im} !== {e.k, e.re, e.im} || tw_re !== 10'h380 || tw_im !== 10'h100) begin
        failures++; $display("FAIL fwd_data: k=%0d re=%h im=%h req k=%0d re=%h im=%h", tw_k, tw_re, tw_im, e.k, e.re, e.im);
      end
    end
    @(negedge clk); checks++;
    if (tw_valid !== 1'b0) begin failures++; $display("FAIL fwd_drop: tw_valid=%b req 0", tw_valid); end
  endtask

  task automatic test_wrap_sat();
    exp_t e; int n;
    rom_mem[384] = 10'h200;
    for (int t = 0; t < 2; t++) begin
      send(9'd0, 1'(t));
      @(negedge clk); checks++;
      if (rom_addr !== 9'd0) begin failures++; $display("FAIL wrap_addr0: addr=%0d req 0", rom_addr); end
      @(negedge clk); checks++;
      if (rom_addr !== 9'd384) begin failures++; $display("FAIL wrap_addr1: addr=%0d req 384", rom_addr); end
      n = 0;
      while (!tw_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!tw_valid || sb.size() == 0) begin
        failures++; $display("FAIL wrap_timeout: tw_valid=%b sb=%0d", tw_valid, sb.size());
      end else begin
        e = sb.pop_front();
        if ({tw_k, tw_re, tw_im} !== {e.k, e.re, e.im} || tw_re !== 10'h300 ||
            tw_im !== (t == 0 ? 10'h1FF : 10'h200)) begin
          failures++; $display("FAIL wrap_sat inv=%0d: re=%h im=%h req re=%h im=%h", t, tw_re, tw_im, e.re, e.im);
        end
      end
      @(negedge clk);
    end
    rom_mem[384] = D'(384 - 256);
  endtask

  task automatic test_backpressure();
    exp_t e; int n; logic [D-1:0] re0, im0; logic [A-1:0] k0;
    tw_ready = 1'b0;
    send(9'd200, 1'b0);
    n = 0;
    while (!tw_valid && n < 20) begin @(negedge clk); n++; end
    re0 = tw_re; im0 = tw_im; k0 = tw_k;
    req_valid = 1'b1; req_k = 9'd77;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); checks++;
      if (tw_valid !== 1'b1 || {tw_re, tw_im, tw_k} !== {re0, im0, k0} || req_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold c=%0d: valid=%b re=%h im=%h k=%0d rdy=%b", c, tw_valid, tw_re, tw_im, tw_k, req_ready);
      end
    end
    req_valid = 1'b0; tw_ready = 1'b1;
    checks++;
    if (sb.size() != 1) begin
      failures++; $display("FAIL bp_sb: entries=%0d req 1", sb.size());
    end else begin
      e = sb.pop_front();
      if ({tw_k, tw_re, tw_im} !== {e.k, e.re, e.im}) begin
        failures++; $display("FAIL bp_data: k=%0d re=%h im=%h req k=%0d re=%h im=%h", tw_k, tw_re, tw_im, e.k, e.re, e.im);
      end
    end
    @(negedge clk); checks++;
    if (tw_valid !== 1'b0) begin failures++; $display("FAIL bp_release: tw_valid=%b req 0", tw_valid); end
  endtask

  task automatic test_back_to_back();
    logic [A-1:0] ks [4] = '{9'd1, 9'd2, 9'd3, 9'd511};
    exp_t e; int i = 0, got = 0, cyc = 0, last_acc = -1; logic acc;
    tw_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_k = ks[0]; req_inv = 1'b0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      if (tw_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL b2b_sb: output with empty scoreboard k=%0d", tw_k);
        end else begin
          e = sb.pop_front();
          if ({tw_k, tw_re, tw_im} !== {e.k, e.re, e.im}) begin
            failures++; $display("FAIL b2b_data: k=%0d re=%h im=%h req k=%0d re=%h im=%h", tw_k, tw_re, tw_im, e.k, e.re, e.im);
          end
        end
        got++;
      end
      if (acc) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 4) begin failures++; $display("FAIL b2b_rate: spacing=%0d req 4", cyc - last_acc); end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        i++;
        if (i < 4) begin req_k = ks[i]; req_inv = 1'(i); end
        else req_valid = 1'b0;
      end
    end
    checks++;
    if (got != 4) begin failures++; $display("FAIL b2b_count: outputs=%0d req 4", got); end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    exp_t e; int n;
    send(9'd77, 1'b0);
    @(posedge clk); #1;      // now in S_SIN
    rstn = 1'b0;
    @(negedge clk); checks++;
    if ({tw_valid, tw_re, tw_im, tw_k, rom_addr} !== '0) begin
      failures++; $display("FAIL mid_reset: valid=%b re=%h im=%h k=%0d addr=%0d req 0s", tw_valid, tw_re, tw_im, tw_k, rom_addr);
    end
    @(posedge clk); #1; rstn = 1'b1;
    sb.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); checks++;
      if (tw_valid !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d: tw_valid=%b req 0", c, tw_valid); end
    end
    send(9'd5, 1'b0);
    n = 0;
    while (!tw_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!tw_valid || sb.size() != 1) begin
      failures++; $display("FAIL mid_new: tw_valid=%b sb=%0d req 1,1", tw_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if ({tw_k, tw_re, tw_im} !== {e.k, e.re, e.im}) begin
        failures++; $display("FAIL mid_data: k=%0d re=%h im=%h req k=%0d re=%h im=%h", tw_k, tw_re, tw_im, e.k, e.re, e.im);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    load_rom();
    test_reset();
    test_forward();
    test_wrap_sat();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
